// File: rtl/mvm_weight_loader.sv
// Weight-preload source for the MVM mesh: buffers 512-bit weight rows in a small
// show-ahead FIFO and emits one AXI-Stream flit per row with a register-file write header.
module mvm_weight_loader #(
  parameter int DATAW      = 512,
  parameter int USERW      = 75,
  parameter int IDW        = 2,
  parameter int DESTW      = 4,
  parameter int DPES       = 64,
  parameter int RF_DEPTH   = 512,
  parameter int FIFO_DEPTH = 8,
  localparam int ADDRW     = $clog2(RF_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [DESTW-1:0]         cmd_dest,
  input  logic [5:0]               cmd_dpe,
  input  logic [ADDRW:0]           cmd_count,
  input  logic                     data_wen,
  input  logic [DATAW-1:0]         data_wdata,
  output logic                     data_rdy,
  output logic                     axis_tx_tvalid,
  input  logic                     axis_tx_tready,
  output logic [DATAW+USERW-1:0]   axis_tx_tdata,
  output logic [IDW-1:0]           axis_tx_tid,
  output logic [DESTW-1:0]         axis_tx_tdest,
  output logic                     axis_tx_tlast,
  output logic                     busy,
  output logic                     done
);
  // state | meaning
  // IDLE  | waiting for a load command; rows may still be buffered
  // SEND  | streaming one flit per buffered row until count rows are sent

  localparam int PTRW    = $clog2(FIFO_DEPTH);
  localparam int OPC_LSB = 9;
  localparam int EN_LSB  = 11;

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [DESTW-1:0]  dest_q, dest_d;
  logic [5:0]        dpe_q, dpe_d;
  logic [ADDRW:0]    count_q, count_d;
  logic [ADDRW:0]    sent_q, sent_d;
  logic [ADDRW-1:0]  addr_q, addr_d;
  logic              done_q, done_d;
  logic              init_q;

  logic [DATAW-1:0]  mem_q [FIFO_DEPTH];
  logic [PTRW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTRW:0]     occ_q, occ_d;
  logic              full, empty, push, pop;

  logic [DPES-1:0]   rf_en;
  logic [USERW-1:0]  hdr;

  // init_q keeps the ready outputs low until the first clock after reset release
  assign full      = (occ_q == (PTRW+1)'(FIFO_DEPTH));
  assign empty     = (occ_q == '0);
  assign data_rdy  = init_q & ~full;
  assign push      = data_wen & data_rdy;
  assign pop       = axis_tx_tvalid & axis_tx_tready;

  assign busy           = (state_q == SEND);
  assign cmd_ready      = init_q & (state_q == IDLE);
  assign axis_tx_tvalid = busy & ~empty;
  assign axis_tx_tlast  = busy & (sent_q == count_q - (ADDRW+1)'(1));
  assign axis_tx_tid    = '0;
  assign axis_tx_tdest  = busy ? dest_q : '0;
  assign axis_tx_tdata  = axis_tx_tvalid ? {hdr, mem_q[rptr_q]} : '0;
  assign done           = done_q;

  always_comb begin
    rf_en = '0;
    if (int'(dpe_q) < DPES) rf_en[dpe_q] = 1'b1;
    hdr = '0;
    hdr[ADDRW-1:0]      = addr_q;
    hdr[OPC_LSB +: 2]   = 2'b11;
    hdr[EN_LSB +: DPES] = rf_en;
  end

  always_comb begin
    wptr_d = wptr_q + PTRW'(push);
    rptr_d = rptr_q + PTRW'(pop);
    occ_d  = occ_q + (PTRW+1)'(push) - (PTRW+1)'(pop);
  end

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    dpe_d   = dpe_q;
    count_d = count_q;
    sent_d  = sent_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_ready && cmd_valid) begin
          dest_d  = cmd_dest;
          dpe_d   = cmd_dpe;
          count_d = cmd_count;
          sent_d  = '0;
          addr_d  = '0;
          if (cmd_count == '0) done_d = 1'b1;
          else                 state_d = SEND;
        end
      end
      SEND: begin
        if (pop) begin
          addr_d = addr_q + ADDRW'(1);
          sent_d = sent_q + (ADDRW+1)'(1);
          if (axis_tx_tlast) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dest_q  <= '0;
      dpe_q   <= '0;
      count_q <= '0;
      sent_q  <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      init_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      dpe_q   <= dpe_d;
      count_q <= count_d;
      sent_q  <= sent_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      init_q  <= 1'b1;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      occ_q   <= occ_d;
    end
  end

  // Row storage carries no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= data_wdata;
  end

endmodule

// File: doc/mvm_weight_loader.md
# mvm_weight_loader

Hardware weight-preload source for the MVM mesh: accepts a load command (destination node, DPE index, word count) and a stream of 512-bit weight rows, then injects one AXI-Stream flit per row into its mesh router port. Each flit carries the MVM register-file write header in the upper tdata bits. Sits at the weight-loader node (node 13 in the 4x4 MLP mapping), directly upstream of `axis_mesh`, and feeds the MVM nodes' register files.

## Interface
- `DATAW`, 512, weight row width (64 lanes x 8 bit).
- `USERW`, 75, header width appended above tdata; must be ≥ 11 + `DPES`.
- `IDW`, 2, tid width.
- `DESTW`, 4, tdest width.
- `DPES`, 64, dot-product engines per MVM.
- `RF_DEPTH`, 512, register-file words per DPE; `ADDRW` = clog2(`RF_DEPTH`) = 9.
- `FIFO_DEPTH`, 8, data FIFO entries (power of two).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_dest` in `DESTW`: destination MVM node ID.
- `cmd_dpe` in 6: target DPE index.
- `cmd_count` in `ADDRW`+1: rows to send.
- `data_wen` in 1 / `data_wdata` in `DATAW`: row write into FIFO.
- `data_rdy` out 1: FIFO not full.
- `axis_tx_tvalid` out 1 / `axis_tx_tready` in 1: mesh handshake.
- `axis_tx_tdata` out `DATAW`+`USERW`: {header, row}.
- `axis_tx_tid` out `IDW`: constant 0.
- `axis_tx_tdest` out `DESTW`: latched `cmd_dest`.
- `axis_tx_tlast` out 1: final row of command.
- `busy` out 1: high in SEND.
- `done` out 1: one-cycle pulse at command completion.

## Operation
- Header, in `axis_tx_tdata[DATAW +: USERW]`: bits [8:0] = rf_addr; bits [10:9] = 2'b11 (weight-write opcode); bits [11 +: DPES] = one-hot rf_en = 1 << `cmd_dpe`. Remaining bits are 0. If `cmd_dpe` ≥ `DPES`, rf_en is all zeros and the flits are still sent.
- Row data sits in `axis_tx_tdata[DATAW-1:0]` unchanged, taken from the FIFO head.
- FIFO: show-ahead, depth `FIFO_DEPTH`. `data_rdy` = !full. A write with `data_wen`=1 while full is dropped, even if a pop occurs in the same cycle. A simultaneous push and pop when not full keeps the occupancy unchanged. Rows may be written before the command arrives.
- FSM states:
  - IDLE: `cmd_ready`=1. On `cmd_valid`, latch dest, dpe and count, and clear the address counter. If count=0, pulse `done` next cycle and stay in IDLE. Otherwise go to SEND.
  - SEND: `cmd_ready`=0, `busy`=1, `axis_tx_tvalid` = FIFO non-empty. On handshake (tvalid & tready): pop FIFO, increment rf_addr (wraps modulo 2^ADDRW), increment sent count. `axis_tx_tlast` = (sent == count-1). On the handshake of the tlast flit, go to IDLE and pulse `done` in the next cycle.
- tvalid is never asserted in IDLE, even if the FIFO holds data.
- A held flit keeps tdata, tdest and tlast stable while tvalid=1 and tready=0.

## Timing
- Reset values: `cmd_ready`=0 while `rst`=1, then 1 from the first cycle after release. All other outputs are 0: `axis_tx_*`, `busy`, `done`, `data_rdy`. `data_rdy` goes to 1 one cycle after release. FIFO is emptied and the FSM goes to IDLE.
- Command accepted in cycle t: `busy`=1 from t+1. If the FIFO is non-empty, `axis_tx_tvalid`=1 in t+1.
- Row written in cycle t into an empty FIFO during SEND: visible on `axis_tx_tdata` with tvalid=1 in t+1.
- With tready held high and rows available: one flit per cycle, and N rows take N cycles.
- Last handshake in cycle t: `busy`=0 and `done`=1 in t+1. A new command can be accepted in t+1.
- Reset asserted mid-SEND: outputs clear immediately (async). Remaining rows and the partial command are discarded, and no `done` pulse is produced.

## Test plan
- Reset/idle: assert `rst` with the FIFO holding 3 rows. Required: all outputs 0 during reset. After release: `cmd_ready`=1, `data_rdy`=1, tvalid=0 with 0 rows held.
- Basic load: cmd dest=2, dpe=5, count=4; rows 0x11..0x14; tready=1. Required:
  - 4 consecutive flits with tdest=2;
  - header = (1<<16)|(3<<9)|addr for addr 0..3;
  - tlast only on the 4th flit;
  - `done` pulses one cycle later.
- Backpressure: count=3; tready toggles 1,0,0,1,0,1. Required: flits are held stable while tready=0, each row is sent exactly once in order, and tlast accompanies row 3.
- FIFO full: with no command pending, write 9 rows back-to-back. Required: `data_rdy`=0 after the 8th write and the 9th row is dropped. Then cmd count=8 drains exactly rows 1..8.
- Boundaries:
  - count=0 produces `done` with no flits;
  - count=512 (dpe=63) issues addresses 0..511 with rf_en bit 74 set;
  - dpe=70 produces a header with rf_en=0.
- Reset mid-operation: cmd count=6, apply `rst` after 2 flits. Required: no further flits and no `done`. A new cmd count=1 then sends addr 0 with tlast=1.
